// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared constants and helpers for the stopwatch front panel:
//               controller state encoding, ms-to-cycles conversion and the
//               significant-digit mask used by both controller and core.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE   = 2'd0;  // paused, showing live time
    localparam logic [1:0] ST_RUN    = 2'd1;  // running, showing live time
    localparam logic [1:0] ST_LAP    = 2'd2;  // running, showing a frozen lap
    localparam logic [1:0] ST_REVIEW = 2'd3;  // paused, browsing stored laps

    // Converts a millisecond interval to clock cycles, never below one cycle.
    function automatic int ms_to_cycles(input int freq_hz, input int ms);
        int cycles;
        cycles = (freq_hz / 1000) * ms;
        return (cycles < 1) ? 1 : cycles;
    endfunction

    // Lowest three digits always lit, plus every digit up to the highest
    // nonzero nibble, so leading zeros are blanked but "0.00" style stays.
    function automatic logic [7:0] digit_enable(input logic [31:0] value);
        logic [7:0] en;
        logic       seen;
        en   = '0;
        seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (value[i*4 +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            en[i] = seen || (i < 3);
        end
        return en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer plus stability-counter debouncer for a
//               single active-high button; emits a one-cycle press pulse on
//               each accepted rising level.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt     <= '0;
            level     <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= level;
            if (r_sync2 != level) begin
                if (r_cnt == CNT_LAST) begin
                    level <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Front-panel controller: debounces start/lap/clear, drives the
//               core's start/clear pulses, keeps a circular lap buffer and
//               selects live time, a held lap or a lap review for display.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int FREQ_HZ     = 100000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LAP_HOLD_MS = 2000,
    parameter int LAP_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_start_raw,
    input  logic        btn_lap_raw,
    input  logic        btn_clear_raw,
    input  logic [31:0] live_time,
    output logic        sw_start,
    output logic        sw_clear,
    output logic [31:0] disp_value,
    output logic [7:0]  disp_digit_en,
    output logic [7:0]  disp_dp_en,
    output logic        running,
    output logic [3:0]  lap_count,
    output logic [2:0]  lap_sel
);

    localparam int              DEBOUNCE_CYCLES = ms_to_cycles(FREQ_HZ, DEBOUNCE_MS);
    localparam int              LAP_HOLD_CYCLES = ms_to_cycles(FREQ_HZ, LAP_HOLD_MS);
    localparam int              HOLD_W          = (LAP_HOLD_CYCLES > 1) ? $clog2(LAP_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD   = HOLD_W'(LAP_HOLD_CYCLES - 1);
    localparam logic [3:0]      DEPTH_COUNT     = 4'(LAP_DEPTH);
    // Depth is a power of two, so masking implements the modulo wrap
    localparam logic [2:0]      PTR_MASK        = 3'(LAP_DEPTH - 1);

    logic        w_press_start, w_press_lap, w_press_clear;
    logic        level_start, level_lap, level_clear;
    logic        unused_levels;
    logic        w_start, w_clear, w_lap, w_capture, w_frozen;
    logic [1:0]  r_state;
    logic [2:0]  r_wr_ptr;
    logic [2:0]  w_rd_idx;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [31:0] lap_mem [LAP_DEPTH];
    logic [31:0] w_lap_value;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .resetn(resetn), .raw(btn_start_raw), .level(level_start), .press(w_press_start));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk(clk), .resetn(resetn), .raw(btn_lap_raw), .level(level_lap), .press(w_press_lap));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk(clk), .resetn(resetn), .raw(btn_clear_raw), .level(level_clear), .press(w_press_clear));

    // Debounced levels are not needed here; only the press edges drive the FSM
    assign unused_levels = ^{level_start, level_lap, level_clear};

    // Start wins over clear, clear over lap; losers in the same cycle are dropped
    assign w_start   = w_press_start;
    assign w_clear   = w_press_clear & ~w_press_start;
    assign w_lap     = w_press_lap & ~w_press_start & ~w_press_clear;
    assign w_capture = w_lap && ((r_state == ST_RUN) || (r_state == ST_LAP));

    // Main sequencer: state, core pulses, lap bookkeeping and hold timer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            sw_start   <= 1'b0;
            sw_clear   <= 1'b0;
            lap_count  <= 4'd0;
            lap_sel    <= 3'd0;
            r_wr_ptr   <= 3'd0;
            r_hold_cnt <= '0;
        end else begin
            sw_start <= w_start;
            sw_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                    end else if (w_clear) begin
                        sw_clear  <= 1'b1;
                        lap_count <= 4'd0;
                        r_wr_ptr  <= 3'd0;
                    end else if (w_lap && (lap_count != 4'd0)) begin
                        r_state <= ST_REVIEW;
                        lap_sel <= 3'd0;
                    end
                end
                ST_RUN, ST_LAP: begin
                    if (w_start) begin
                        r_state <= ST_IDLE;
                    end else if (w_lap) begin
                        r_state    <= ST_LAP;
                        r_hold_cnt <= HOLD_RELOAD;
                        lap_sel    <= 3'd0;
                    end else if (r_state == ST_LAP) begin
                        if (r_hold_cnt == '0) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 1'b1;
                        end
                    end
                end
                ST_REVIEW: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                    end else if (w_clear) begin
                        sw_clear  <= 1'b1;
                        lap_count <= 4'd0;
                        r_wr_ptr  <= 3'd0;
                        r_state   <= ST_IDLE;
                    end else if (w_lap) begin
                        if ({1'b0, lap_sel} == (lap_count - 4'd1)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            lap_sel <= lap_sel + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_capture) begin
                r_wr_ptr <= (r_wr_ptr + 3'd1) & PTR_MASK;
                if (lap_count != DEPTH_COUNT) begin
                    lap_count <= lap_count + 4'd1;
                end
            end
        end
    end

    // Lap storage: one register per entry, written at the current write pointer
    generate
        for (genvar i = 0; i < LAP_DEPTH; i++) begin : g_lap_mem
            always_ff @(posedge clk) begin
                if (w_capture && (r_wr_ptr == 3'(i))) begin
                    lap_mem[i] <= live_time;
                end
            end
        end
    endgenerate

    // Newest lap first: walk backwards from the write pointer
    assign w_rd_idx = (r_wr_ptr - 3'd1 - lap_sel) & PTR_MASK;

    // Read mux for the selected lap entry
    always_comb begin
        w_lap_value = lap_mem[0];
        for (int i = 1; i < LAP_DEPTH; i++) begin
            if (w_rd_idx == 3'(i)) begin
                w_lap_value = lap_mem[i];
            end
        end
    end

    assign w_frozen      = (r_state == ST_LAP) || (r_state == ST_REVIEW);
    assign disp_value    = w_frozen ? w_lap_value : live_time;
    assign disp_digit_en = digit_enable(disp_value);
    // No decimal points marks a frozen (non-live) value
    assign disp_dp_en    = w_frozen ? 8'h00 : disp_digit_en;
    assign running       = (r_state == ST_RUN) || (r_state == ST_LAP);

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl with a queue-based
//               reference model and a pulse scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int HOLD_CYC = 5;   // 1000 Hz * 5 ms / 1000
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        bs = 1'b0, bl = 1'b0, bc = 1'b0;
    logic [31:0] live_time = 32'd0;
    logic        sw_start, sw_clear, running;
    logic [31:0] disp_value;
    logic [7:0]  disp_digit_en, disp_dp_en;
    logic [3:0]  lap_count;
    logic [2:0]  lap_sel;

    stopwatch_ctrl #(
        .FREQ_HZ(1000), .DEBOUNCE_MS(2), .LAP_HOLD_MS(5), .LAP_DEPTH(4)
    ) dut (
        .clk(clk), .resetn(resetn),
        .btn_start_raw(bs), .btn_lap_raw(bl), .btn_clear_raw(bc),
        .live_time(live_time),
        .sw_start(sw_start), .sw_clear(sw_clear),
        .disp_value(disp_value), .disp_digit_en(disp_digit_en), .disp_dp_en(disp_dp_en),
        .running(running), .lap_count(lap_count), .lap_sel(lap_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit is_clear;
        int cyc;
    } pulse_t;
    pulse_t exp_q[$];
    pulse_t mon_p;

    // Reference model: abstract run flag, review flag, freeze deadline, lap list
    bit          m_run = 1'b0;
    bit          m_review = 1'b0;
    int          m_freeze_end = 0;
    int          m_sel = 0;
    logic [31:0] m_laps[$];      // index 0 = newest
    bit          vary_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_digits(input logic [31:0] v);
        int top;
        top = 2;
        for (int i = 3; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) top = i;
        return 8'((1 << (top + 1)) - 1);
    endfunction

    task automatic check_outputs();
        bit          frozen;
        logic [31:0] ev;
        frozen = m_review || (m_run && (cyc < m_freeze_end));
        ev     = frozen ? m_laps[m_sel] : live_time;
        chk("running", {31'd0, running}, {31'd0, m_run});
        chk("lap_count", {28'd0, lap_count}, m_laps.size());
        chk("disp_value", disp_value, ev);
        chk("digit_en", {24'd0, disp_digit_en}, {24'd0, ref_digits(ev)});
        chk("dp_en", {24'd0, disp_dp_en}, frozen ? 32'd0 : {24'd0, ref_digits(ev)});
        if (frozen) chk("lap_sel", {29'd0, lap_sel}, m_sel);
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (vary_live) live_time = $urandom;
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_review = 1'b0; m_freeze_end = 0; m_sel = 0;
        m_laps.delete();
        exp_q.delete();
    endtask

    // Called just before the edge at which the debounced press is acted on
    task automatic model_press(input bit s, input bit c, input bit l);
        int e;
        e = cyc + 1;
        if (s) begin
            exp_q.push_back('{is_clear: 1'b0, cyc: e});
            if (m_review) begin
                m_review = 1'b0;
                m_run    = 1'b1;
            end else begin
                m_run = !m_run;
            end
            m_freeze_end = 0;
        end else if (c) begin
            if (!m_run) begin
                exp_q.push_back('{is_clear: 1'b1, cyc: e});
                m_laps.delete();
                m_review = 1'b0;
            end
        end else if (l) begin
            if (m_run) begin
                m_laps.push_front(live_time);
                if (m_laps.size() > DEPTH) void'(m_laps.pop_back());
                m_sel        = 0;
                m_freeze_end = e + HOLD_CYC;
            end else if (m_review) begin
                if (m_sel == m_laps.size() - 1) m_review = 1'b0;
                else m_sel++;
            end else if (m_laps.size() > 0) begin
                m_review = 1'b1;
                m_sel    = 0;
            end
        end
    endtask

    // Raw rise, 2 sync + 2 debounce cycles, then the press is live for one cycle
    task automatic do_press(input bit s, input bit c, input bit l, input int hold_after, input int settle);
        tick();
        bs = s; bc = c; bl = l;
        repeat (4) tick();
        model_press(s, c, l);
        repeat (hold_after) tick();
        bs = 1'b0; bc = 1'b0; bl = 1'b0;
        repeat (settle) tick();
    endtask

    task automatic glitch(input int which);
        tick();
        case (which)
            0:       bs = 1'b1;
            1:       bc = 1'b1;
            default: bl = 1'b1;
        endcase
        tick();
        bs = 1'b0; bc = 1'b0; bl = 1'b0;
        repeat (6) tick();
    endtask

    // Pulse scoreboard: every sw_start/sw_clear must match the next expectation
    always @(negedge clk) begin
        if (sw_start || sw_clear) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse at cycle %0d: sw_start=%0b sw_clear=%0b, want none",
                         cyc, sw_start, sw_clear);
            end else begin
                mon_p = exp_q.pop_front();
                chk("pulse_kind", {30'd0, sw_clear, sw_start}, mon_p.is_clear ? 32'd2 : 32'd1);
                chk("pulse_cycle", cyc, mon_p.cyc);
            end
        end else if ((exp_q.size() > 0) && (cyc > exp_q[0].cyc)) begin
            mon_p = exp_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missing_pulse at cycle %0d: got none, want %s at cycle %0d",
                     cyc, mon_p.is_clear ? "sw_clear" : "sw_start", mon_p.cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int r;
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Glitch must be rejected, clean press starts the core
        glitch(0);
        do_press(1'b1, 1'b0, 1'b0, 6, 6);

        // Single lap capture and hold expiry
        live_time = 32'h00012345;
        do_press(1'b0, 1'b0, 1'b1, 0, 8);
        live_time = 32'h00099999;
        repeat (2) tick();

        // Overfill the lap buffer, pause, then review newest-first
        for (int v = 1; v <= 5; v++) begin
            live_time = v;
            do_press(1'b0, 1'b0, 1'b1, 1, 6);
        end
        do_press(1'b1, 1'b0, 1'b0, 1, 6);
        for (int k = 0; k < 5; k++) do_press(1'b0, 1'b0, 1'b1, 1, 6);

        // Clear is ignored while running, honoured while paused
        do_press(1'b1, 1'b0, 1'b0, 1, 6);
        do_press(1'b0, 1'b1, 1'b0, 1, 6);
        do_press(1'b1, 1'b0, 1'b0, 1, 6);
        do_press(1'b0, 1'b1, 1'b0, 1, 6);
        do_press(1'b0, 1'b0, 1'b1, 1, 6);

        // Coincident start+clear, then reset while a lap is frozen
        do_press(1'b1, 1'b1, 1'b0, 1, 6);
        live_time = 32'h00000012;
        do_press(1'b0, 1'b0, 1'b1, 1, 0);
        resetn = 1'b0;
        model_reset();
        repeat (2) tick();
        resetn = 1'b1;
        repeat (6) tick();

        // Randomized presses against the model
        vary_live = 1'b1;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:          glitch($urandom_range(0, 2));
                1, 2, 3:    do_press(1'b0, 1'b0, 1'b1, $urandom_range(0, 6), $urandom_range(5, 8));
                4, 5:       do_press(1'b1, 1'b0, 1'b0, $urandom_range(0, 6), $urandom_range(5, 8));
                6:          do_press(1'b0, 1'b1, 1'b0, $urandom_range(0, 6), $urandom_range(5, 8));
                7:          do_press(1'b1, 1'b0, 1'b1, $urandom_range(0, 6), $urandom_range(5, 8));
                8:          do_press(1'b0, 1'b1, 1'b1, $urandom_range(0, 6), $urandom_range(5, 8));
                default:    do_press(1'b1, 1'b1, 1'b1, $urandom_range(0, 6), $urandom_range(5, 8));
            endcase
        end
        vary_live = 1'b0;
        repeat (8) tick();

        chk("pending_pulses", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
